craft_round_controller: RTL and testbench

Sequencer for the CRAFT encryption datapath. Accepts a start request, pulses the datapath load, and runs NUM_ROUNDS single-cycle rounds. Per round it drives the round index, the tweakey select and a last-round flag, and holds the round-constant LFSR generator in reset outside the round window. It sits between the top-level stream handshake and the round datapath and constant generator, and presents the finished block through a valid/ready output.

---
 rtl/craft_pkg.sv | 24 ++
 rtl/craft_rc_shadow.sv | 46 ++++
 rtl/craft_round_controller.sv | 125 ++++++++++++
 tb/tb_craft_round_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/craft_pkg.sv
// Shared types and constants for the CRAFT round sequencer and its round-constant shadow checker.
package craft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] RC_INIT          = 8'h11;
    localparam int         CRAFT_NUM_ROUNDS = 32;
    localparam int         TK_SEL_W         = 2;

    // Round-constant LFSRs: new MSB is the XOR of the two lowest bits, the rest shifts right.
    function automatic logic [3:0] lfsr_a_next(input logic [3:0] a);
        return {a[0] ^ a[1], a[3:1]};
    endfunction

    function automatic logic [2:0] lfsr_b_next(input logic [2:0] b);
        return {b[0] ^ b[1], b[2:1]};
    endfunction

endpackage

// File: rtl/craft_rc_shadow.sv
// Shadow copy of the CRAFT round-constant LFSR pair with a sticky mismatch flag.
// Only instantiated when CRAFT_RC_CHECK_EN is defined.
module craft_rc_shadow
    import craft_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rc_rst,
    input  logic       round_en,
    input  logic       clr,
    input  logic [7:0] rc,
    output logic       rc_err
);

    logic [3:0] a_q;
    logic [2:0] b_q;
    logic       err_q;
    logic [7:0] rc_exp;

    assign rc_exp = {a_q, 1'b0, b_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= RC_INIT[7:4];
            b_q   <= RC_INIT[2:0];
            err_q <= 1'b0;
        end else begin
            // Tracks the external generator: held at the seed while rc_rst, one step per round.
            if (rc_rst) begin
                a_q <= RC_INIT[7:4];
                b_q <= RC_INIT[2:0];
            end else begin
                a_q <= lfsr_a_next(a_q);
                b_q <= lfsr_b_next(b_q);
            end
            if (clr) begin
                err_q <= 1'b0;
            end else if (round_en && (rc != rc_exp)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rc_err = err_q;

endmodule

// File: rtl/craft_round_controller.sv
// CRAFT round sequencer: start -> LOAD pulse -> NUM_ROUNDS single-cycle rounds -> DONE with valid/ready.
// Optional build macro CRAFT_RC_CHECK_EN adds a shadow round-constant checker driving rc_err.
module craft_round_controller
    import craft_pkg::*;
#(
    parameter int NUM_ROUNDS = CRAFT_NUM_ROUNDS,
    parameter int RIDX_W     = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                start_ready,
    output logic                busy,
    output logic                ld,
    output logic                round_en,
    output logic [RIDX_W-1:0]   round_idx,
    output logic [TK_SEL_W-1:0] tk_sel,
    output logic                last_round,
    output logic                rc_rst,
    input  logic [7:0]          rc,
    output logic                rc_err,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NUM_ROUNDS - 1);

    state_t              state_q;
    logic                busy_q;
    logic                ld_q;
    logic                round_en_q;
    logic [RIDX_W-1:0]   round_idx_q;
    logic [RIDX_W-1:0]   round_idx_d;
    logic                last_round_q;
    logic                out_valid_q;
    logic                start_acc;

    assign round_idx_d = round_idx_q + RIDX_W'(1);

    // DONE accepts a new block only in the same cycle the current one is taken downstream.
    assign start_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign start_acc   = start && start_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            ld_q         <= 1'b0;
            round_en_q   <= 1'b0;
            round_idx_q  <= '0;
            last_round_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                        ld_q    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_q      <= ST_ROUND;
                    ld_q         <= 1'b0;
                    round_en_q   <= 1'b1;
                    round_idx_q  <= '0;
                    last_round_q <= 1'b0;
                end
                ST_ROUND: begin
                    if (round_idx_q == LAST_IDX) begin
                        state_q      <= ST_DONE;
                        round_en_q   <= 1'b0;
                        round_idx_q  <= '0;
                        last_round_q <= 1'b0;
                        out_valid_q  <= 1'b1;
                    end else begin
                        round_idx_q  <= round_idx_d;
                        last_round_q <= (round_idx_d == LAST_IDX);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (start) begin
                            state_q <= ST_LOAD;
                            ld_q    <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign ld         = ld_q;
    assign round_en   = round_en_q;
    assign round_idx  = round_idx_q;
    assign tk_sel     = round_idx_q[TK_SEL_W-1:0];
    assign last_round = last_round_q;
    assign out_valid  = out_valid_q;
    assign rc_rst     = (state_q != ST_ROUND);

`ifdef CRAFT_RC_CHECK_EN
    craft_rc_shadow u_rc_shadow (
        .clk      (clk),
        .rst      (rst),
        .rc_rst   (rc_rst),
        .round_en (round_en_q),
        .clr      (start_acc),
        .rc       (rc),
        .rc_err   (rc_err)
    );
`else
    logic unused_rc;
    assign unused_rc = ^{rc, start_acc};
    assign rc_err    = 1'b0;
`endif

endmodule

// File: tb/tb_craft_round_controller.sv
// Scoreboard bench for craft_round_controller: stimulus pushes expected ld/round/done events, a monitor pops them.
module tb_craft_round_controller;

    localparam int NR = 32;
`ifdef CRAFT_RC_CHECK_EN
    localparam bit RC_CHK = 1'b1;
`else
    localparam bit RC_CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] rc;
    logic       start_ready, busy, ld, round_en, last_round, rc_rst, rc_err, out_valid;
    logic [4:0] round_idx;
    logic [1:0] tk_sel;

    craft_round_controller #(.NUM_ROUNDS(NR), .RIDX_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_ready (start_ready),
        .busy        (busy),
        .ld          (ld),
        .round_en    (round_en),
        .round_idx   (round_idx),
        .tk_sel      (tk_sel),
        .last_round  (last_round),
        .rc_rst      (rc_rst),
        .rc          (rc),
        .rc_err      (rc_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External round-constant generator stand-in, with an optional fault injection at one round.
    logic [3:0] ga;
    logic [2:0] gb;
    logic       force_en = 1'b0;
    int         force_idx = 5;
    always @(posedge clk) begin
        if (rc_rst) begin
            ga <= 4'h1;
            gb <= 3'h1;
        end else begin
            ga <= {ga[0] ^ ga[1], ga[3:1]};
            gb <= {gb[0] ^ gb[1], gb[2:1]};
        end
    end
    assign rc = (force_en && round_en && (int'(round_idx) == force_idx)) ? 8'h00 : {ga, 1'b0, gb};

    typedef struct {
        int         cyc;
        int         kind;   // 0 = ld, 1 = round, 2 = done
        int         idx;
        bit         err;
        bit         chk_rc;
        logic [7:0] rc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    logic [7:0] rc_tab [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic push_ev(input int c, input int k, input int i, input bit e);
        exp_t x;
        x.cyc    = c;
        x.kind   = k;
        x.idx    = i;
        x.err    = e;
        x.chk_rc = RC_CHK && (k == 1) && (i < 4);
        x.rc     = (i < 4) ? rc_tab[i] : 8'h00;
        q.push_back(x);
    endtask

    // Block whose start is accepted in cycle t: ld at t+1, rounds at t+2.., done from t+NR+2.
    task automatic push_block(input int t, input int hold, input int err_from, input int upto);
        push_ev(t + 1, 0, 0, 1'b0);
        for (int i = 0; i < upto; i++)
            push_ev(t + 2 + i, 1, i, RC_CHK && (err_from >= 0) && (i > err_from));
        if (upto == NR)
            for (int h = 0; h <= hold; h++)
                push_ev(t + NR + 2 + h, 2, 0, RC_CHK && (err_from >= 0));
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    exp_t mon_e;
    logic [2:0] kv;
    always @(negedge clk) begin
        if (!rst && (ld || round_en || out_valid)) begin
            if (q.size() == 0) begin
                chk("unexpected_event", {29'd0, ld, round_en, out_valid}, 32'd0);
            end else begin
                mon_e = q.pop_front();
                kv = (mon_e.kind == 0) ? 3'b100 : (mon_e.kind == 1) ? 3'b010 : 3'b001;
                chk("event_cycle", cyc, mon_e.cyc);
                chk("ld_round_valid", {29'd0, ld, round_en, out_valid}, {29'd0, kv});
                chk("busy", busy, 1);
                chk("rc_rst", rc_rst, (mon_e.kind != 1));
                chk("rc_err", rc_err, mon_e.err);
                if (mon_e.kind == 1) begin
                    chk("round_idx", round_idx, mon_e.idx);
                    chk("tk_sel", tk_sel, mon_e.idx % 4);
                    chk("last_round", last_round, (mon_e.idx == NR - 1));
                end else begin
                    chk("round_idx_zero", round_idx, 0);
                end
                if (mon_e.chk_rc) chk("rc_value", rc, mon_e.rc);
                if (mon_e.kind == 2 && out_ready)
                    $display("block out: cycle %0d rc_err=%0d", cyc, rc_err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 20000", cyc);
        $fatal(1, "watchdog");
    end

    int t;
    initial begin
        rc_tab[0] = 8'h11; rc_tab[1] = 8'h84; rc_tab[2] = 8'h42; rc_tab[3] = 8'h25;
        repeat (3) @(negedge clk);
        chk("rst_start_ready", start_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ld", ld, 0);
        chk("rst_round_en", round_en, 0);
        chk("rst_round_idx", round_idx, 0);
        chk("rst_tk_sel", tk_sel, 0);
        chk("rst_last_round", last_round, 0);
        chk("rst_rc_rst", rc_rst, 1);
        chk("rst_rc_err", rc_err, 0);
        chk("rst_out_valid", out_valid, 0);
        #1 rst = 1'b0;
        @(negedge clk);

        // Single block, out_ready high.
        t = cyc; start = 1'b1; push_block(t, 0, -1, NR);
        @(negedge clk); start = 1'b0;
        wait_until(t + NR + 4);
        chk("idle_after_single", {30'd0, busy, start_ready}, 32'b01);

        // out_ready low for 5 DONE cycles; start during the hold is ignored.
        out_ready = 1'b0;
        t = cyc; start = 1'b1; push_block(t, 5, -1, NR);
        @(negedge clk); start = 1'b0;
        wait_until(t + NR + 3);
        chk("hold_start_ready", start_ready, 0);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("hold_out_valid", out_valid, 1);
        start = 1'b0;
        wait_until(t + NR + 7);
        out_ready = 1'b1;
        @(negedge clk);
        chk("idle_after_hold", {29'd0, busy, out_valid, start_ready}, 32'b001);

        // start held high: three back-to-back blocks NR+2 cycles apart.
        t = cyc; start = 1'b1;
        push_block(t, 0, -1, NR);
        push_block(t + NR + 2, 0, -1, NR);
        push_block(t + 2 * (NR + 2), 0, -1, NR);
        wait_until(t + 2 * (NR + 2) + 1);
        start = 1'b0;
        wait_until(t + 3 * (NR + 2) + 2);
        chk("idle_after_b2b", busy, 0);

        // Reset while round 10 is executing.
        t = cyc; start = 1'b1; push_block(t, 0, -1, 11);
        @(negedge clk); start = 1'b0;
        wait_until(t + 12);
        chk("pre_rst_idx", round_idx, 10);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_rc_rst", rc_rst, 1);
        chk("midrst_round_idx", round_idx, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_round_en", round_en, 0);
        chk("midrst_start_ready", start_ready, 1);
        #1 rst = 1'b0;
        @(negedge clk);
        t = cyc; start = 1'b1; push_block(t, 0, -1, NR);
        @(negedge clk); start = 1'b0;
        wait_until(t + NR + 4);

        // Corrupt rc at round 5, then confirm the next accepted start clears the flag.
        force_en = 1'b1;
        t = cyc; start = 1'b1; push_block(t, 0, 5, NR);
        @(negedge clk); start = 1'b0;
        wait_until(t + NR + 4);
        force_en = 1'b0;
        chk("rc_err_sticky_idle", rc_err, RC_CHK);
        t = cyc; start = 1'b1; push_block(t, 0, -1, NR);
        @(negedge clk); start = 1'b0;
        wait_until(t + NR + 4);
        chk("rc_err_cleared", rc_err, 0);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
